// File: rtl/apb_tester_defs.sv
// ----------------------------------------------------------------------------
// apb_tester_defs
// Shared definitions for the APB3 slave memory:
//   apb_state_e  - FSM state encoding (IDLE / SETUP / ACCESS)
//   WAIT_MAX     - largest supported number of wait states per access
//   WAIT_BITS    - width of the wait-state counter
//   wait_load()  - clamps a wait-state parameter into the counter range
// ----------------------------------------------------------------------------
package apb_tester_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int WAIT_MAX  = 15;
    localparam int WAIT_BITS = 4;

    // Out-of-range parameter values are clamped rather than silently truncated.
    function automatic logic [WAIT_BITS-1:0] wait_load(input int ws);
        if (ws > WAIT_MAX) begin
            return WAIT_BITS'(WAIT_MAX);
        end else if (ws < 0) begin
            return '0;
        end else begin
            return WAIT_BITS'(ws);
        end
    endfunction

endpackage

// File: rtl/apb_tester_ram.sv
// ----------------------------------------------------------------------------
// apb_tester_ram
// Single-port MEM_DEPTH x DATA_BITS storage, synchronous write, asynchronous
// read. Contents are not reset.
// Ports:
//   clk    - clock, write happens on its rising edge
//   we     - write enable
//   addr   - word address shared by read and write
//   wdata  - write data
//   rdata  - combinational read data (0 for addresses beyond MEM_DEPTH)
// ----------------------------------------------------------------------------
module apb_tester_ram #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8,
    parameter int MEM_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Guard keeps a non-power-of-two depth from indexing past the array.
    assign rdata = (32'(addr) < MEM_DEPTH) ? mem[addr] : '0;

endmodule

// File: rtl/apb3_slave_mem.sv
// ----------------------------------------------------------------------------
// apb3_slave_mem
// APB3 slave wrapping a small word memory, with programmable wait states,
// error response for unimplemented addresses, saturating statistics counters
// and a sticky protocol-violation flag.
// Ports:
//   PCLK, PRESETn           - clock, asynchronous active-low reset
//   PADDR, PSEL, PENABLE,
//   PWRITE, PWDATA          - APB3 request
//   PRDATA, PREADY, PSLVERR - APB3 response
//   write_count, read_count,
//   err_count               - completed writes / reads / error responses
//   proto_err               - sticky protocol-violation flag
//   fsm_state               - current FSM state (observation only)
//
// Handshake: a transfer is one setup cycle (PSEL=1, PENABLE=0) followed by
// access cycles (PSEL=1, PENABLE=1) with request fields held stable; it
// completes in the access cycle where PREADY=1, which is WAIT_STATES+1 cycles
// after setup. PRDATA/PSLVERR are valid only in that completion cycle and are
// 0 otherwise.
//
// State model: the SETUP state is the bus setup cycle itself, so it is decoded
// from the registered state plus the live PSEL/PENABLE; only IDLE and ACCESS
// are ever held in the state register. Request fields are latched on the edge
// that leaves SETUP.
// ----------------------------------------------------------------------------
module apb3_slave_mem
    import apb_tester_defs::*;
#(
    parameter int ADDR_BITS   = 4,
    parameter int DATA_BITS   = 8,
    parameter int MEM_DEPTH   = 1 << ADDR_BITS,
    parameter int WAIT_STATES = 0,
    parameter int CNT_BITS    = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [ADDR_BITS-1:0] PADDR,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [DATA_BITS-1:0] PWDATA,
    output logic [DATA_BITS-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [CNT_BITS-1:0]  write_count,
    output logic [CNT_BITS-1:0]  read_count,
    output logic [CNT_BITS-1:0]  err_count,
    output logic                 proto_err,
    output apb_state_e           fsm_state
);

    localparam logic [ADDR_BITS:0]   DEPTH_L   = (ADDR_BITS + 1)'(MEM_DEPTH);
    localparam logic [WAIT_BITS-1:0] WAIT_INIT = wait_load(WAIT_STATES);
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = '1;

    apb_state_e           state_q;
    apb_state_e           state;
    apb_state_e           next_state;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [WAIT_BITS-1:0] wait_q;
    logic                 viol;
    logic                 complete;
    logic                 in_range;
    logic                 mem_we;
    logic [DATA_BITS-1:0] ram_rdata;

    // Setup is recognised whenever the slave is idle, which includes the
    // cycle right after a completion (back-to-back transfers).
    always_comb begin
        state = state_q;
        if (state_q == ST_IDLE && PSEL && !PENABLE) begin
            state = ST_SETUP;
        end
    end

    assign fsm_state = state;
    assign in_range  = ({1'b0, addr_q} < DEPTH_L);

    always_comb begin
        next_state = state;
        viol       = 1'b0;
        complete   = 1'b0;
        PREADY     = 1'b1;
        case (state)
            ST_IDLE: begin
                next_state = ST_IDLE;
                if (PSEL && PENABLE) begin
                    viol = 1'b1;
                end
            end
            ST_SETUP: begin
                next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                PREADY = (wait_q == '0);
                // Any dropped control or changed request field aborts.
                if (!PSEL || !PENABLE || (PADDR != addr_q) ||
                    (PWRITE != write_q) || (PWDATA != wdata_q)) begin
                    viol       = 1'b1;
                    next_state = ST_IDLE;
                end else if (wait_q == '0) begin
                    complete   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign mem_we  = complete && write_q && in_range;
    assign PSLVERR = complete && !in_range;
    assign PRDATA  = (complete && !write_q && in_range) ? ram_rdata : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wait_q  <= '0;
        end else if (state == ST_SETUP) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            wait_q  <= WAIT_INIT;
        end else if (state == ST_ACCESS && wait_q != '0) begin
            wait_q  <= wait_q - WAIT_BITS'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            write_count <= '0;
            read_count  <= '0;
            err_count   <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (viol) begin
                proto_err <= 1'b1;
            end
            if (complete) begin
                if (!in_range) begin
                    if (err_count != CNT_MAX) err_count <= err_count + CNT_BITS'(1);
                end else if (write_q) begin
                    if (write_count != CNT_MAX) write_count <= write_count + CNT_BITS'(1);
                end else begin
                    if (read_count != CNT_MAX) read_count <= read_count + CNT_BITS'(1);
                end
            end
        end
    end

    apb_tester_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (PCLK),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_apb3_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_apb3_slave_mem
// Two slaves on one APB bus (separate PSEL):
//   dut_a: WAIT_STATES=0, MEM_DEPTH=16, CNT_BITS=16
//   dut_b: WAIT_STATES=3, MEM_DEPTH=12, CNT_BITS=2
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge. Read data expectations come from a bench memory model and
// travel through exp_q.
// ----------------------------------------------------------------------------
module tb_apb3_slave_mem;
    import apb_tester_defs::*;

    // ---------------- clock / reset ----------------
    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    // ---------------- shared bus ----------------
    logic [3:0] paddr;
    logic       psel_a, psel_b, penable, pwrite;
    logic [7:0] pwdata;

    logic [7:0]  a_prdata, b_prdata;
    logic        a_pready, b_pready, a_pslverr, b_pslverr;
    logic [15:0] a_wc, a_rc, a_ec;
    logic [1:0]  b_wc, b_rc, b_ec;
    logic        a_perr, b_perr;
    apb_state_e  a_st, b_st;

    apb3_slave_mem #(.ADDR_BITS(4), .DATA_BITS(8), .MEM_DEPTH(16),
                     .WAIT_STATES(0), .CNT_BITS(16)) dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel_a),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr),
        .write_count(a_wc), .read_count(a_rc), .err_count(a_ec),
        .proto_err(a_perr), .fsm_state(a_st)
    );

    apb3_slave_mem #(.ADDR_BITS(4), .DATA_BITS(8), .MEM_DEPTH(12),
                     .WAIT_STATES(3), .CNT_BITS(2)) dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel_b),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr),
        .write_count(b_wc), .read_count(b_rc), .err_count(b_ec),
        .proto_err(b_perr), .fsm_state(b_st)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] mdl_a[16];
    logic [7:0] mdl_b[16];
    int n_checks = 0;
    int n_pass   = 0;
    int last_acc;
    int last_lows;
    logic [7:0] last_rdata;
    logic       last_slverr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Leaves PSEL/PENABLE high after completion so the next call starts a
    // back-to-back setup; call bus_idle before anything else.
    task automatic xfer(input bit to_b, input bit wr, input logic [3:0] addr,
                        input logic [7:0] data);
        bit done;
        @(posedge PCLK); #1;
        psel_a  = !to_b;
        psel_b  = to_b;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge PCLK);
        check("setup_pready", to_b ? b_pready : a_pready, 1);
        @(posedge PCLK); #1;
        penable     = 1'b1;
        last_acc    = 0;
        last_lows   = 0;
        last_rdata  = '0;
        last_slverr = 1'b0;
        done        = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            last_acc++;
            if ((to_b ? b_pready : a_pready) === 1'b1) begin
                done        = 1'b1;
                last_rdata  = to_b ? b_prdata : a_prdata;
                last_slverr = to_b ? b_pslverr : a_pslverr;
            end else begin
                last_lows++;
                @(posedge PCLK); #1;
            end
        end
        check("xfer_done", done, 1);
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic wr_op(input bit to_b, input logic [3:0] addr, input logic [7:0] data);
        bit exp_err;
        exp_err = to_b && (addr >= 4'd12);
        xfer(to_b, 1'b1, addr, data);
        check("wr_slverr", last_slverr, exp_err);
        check("wr_prdata", last_rdata, 0);
        if (!exp_err) begin
            if (to_b) mdl_b[addr] = data;
            else      mdl_a[addr] = data;
        end
    endtask

    task automatic rd_op(input bit to_b, input logic [3:0] addr);
        bit exp_err;
        logic [7:0] exp;
        exp_err = to_b && (addr >= 4'd12);
        if (exp_err)   exp_q.push_back(8'h00);
        else if (to_b) exp_q.push_back(mdl_b[addr]);
        else           exp_q.push_back(mdl_a[addr]);
        xfer(to_b, 1'b0, addr, 8'h00);
        exp = exp_q.pop_front();
        check("rd_prdata", last_rdata, exp);
        check("rd_slverr", last_slverr, exp_err);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] ra;
        logic [7:0] rd;
        PRESETn = 1'b0;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_a_pready", a_pready, 1);
        check("rst_a_pslverr", a_pslverr, 0);
        check("rst_a_prdata", a_prdata, 0);
        check("rst_a_counts", {a_wc, a_rc}, 0);
        check("rst_a_err", {a_ec, 15'd0, a_perr}, 0);
        check("rst_a_state", a_st, ST_IDLE);
        check("rst_b_pready", b_pready, 1);
        check("rst_b_counts", {b_wc, b_rc, b_ec, b_perr}, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // ---- slave A, no wait states: write then back-to-back read ----
        wr_op(1'b0, 4'd3, 8'hA5);
        check("a_wr_acc_cycles", last_acc, 1);
        check("a_wr_lows", last_lows, 0);
        rd_op(1'b0, 4'd3);
        check("a_rd_acc_cycles", last_acc, 1);
        bus_idle();
        check("a_wc_1", a_wc, 1);
        check("a_rc_1", a_rc, 1);
        check("a_idle_prdata", a_prdata, 0);
        check("a_idle_state", a_st, ST_IDLE);

        for (int i = 0; i < 4; i++) begin
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom_range(0, 255));
            wr_op(1'b0, ra, rd);
            rd_op(1'b0, ra);
        end
        bus_idle();
        check("a_wc_5", a_wc, 5);
        check("a_rc_5", a_rc, 5);
        check("a_ec_0", a_ec, 0);

        // ---- slave B, 3 wait states ----
        wr_op(1'b1, 4'd2, 8'h11);
        check("b_wr_acc_cycles", last_acc, 4);
        wr_op(1'b1, 4'd5, 8'h22);
        bus_idle();
        check("b_wc_2", b_wc, 2);

        // PADDR changes 2 -> 5 during a waited write access
        @(posedge PCLK); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h77;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        check("viol_wait_pready", b_pready, 0);
        check("viol_state", b_st, ST_ACCESS);
        @(posedge PCLK); #1;
        paddr = 4'd5;
        @(posedge PCLK); #1;
        psel_b = 1'b0; penable = 1'b0;
        @(negedge PCLK);
        check("viol_proto_err", b_perr, 1);
        check("viol_state_idle", b_st, ST_IDLE);
        check("viol_wc_same", b_wc, 2);
        check("viol_a_clean", a_perr, 0);

        // single waited read: PREADY low exactly 3 access cycles
        rd_op(1'b1, 4'd2);
        check("b_rd_lows", last_lows, 3);
        check("b_rd_acc_cycles", last_acc, 4);
        rd_op(1'b1, 4'd5);
        bus_idle();

        // fill every implemented word, counter saturates at 3
        for (int i = 0; i < 12; i++) begin
            wr_op(1'b1, 4'(i), 8'($urandom_range(0, 255)));
        end
        bus_idle();
        check("b_wc_sat", b_wc, 3);

        // unimplemented address
        wr_op(1'b1, 4'd13, 8'h3C);
        bus_idle();
        check("b_ec_1", b_ec, 1);
        rd_op(1'b1, 4'd14);
        bus_idle();
        check("b_ec_2", b_ec, 2);
        for (int i = 0; i < 12; i++) begin
            rd_op(1'b1, 4'(i));
        end
        bus_idle();
        check("b_rc_sat", b_rc, 3);

        // reset pulse in the middle of a waited write
        @(posedge PCLK); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd4; pwdata = ~mdl_b[4];
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        check("rst_mid_b_counts", {b_wc, b_rc, b_ec}, 0);
        check("rst_mid_b_pready", b_pready, 1);
        check("rst_mid_b_perr", b_perr, 0);
        check("rst_mid_a_counts", {a_wc, a_rc, a_ec}, 0);
        psel_b  = 1'b0;
        penable = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        rd_op(1'b1, 4'd4);
        rd_op(1'b0, 4'd3);
        bus_idle();
        check("post_rst_b_wc", b_wc, 0);
        check("post_rst_b_rc", b_rc, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb3_slave_mem.md
APB3_SLAVE_MEM -- requirements
Module: apb3_slave_mem

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 4, the PADDR width.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, the PWDATA/PRDATA width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 1<<ADDR_BITS, the number of words implemented (1..2^ADDR_BITS).
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, the PREADY-low cycles inserted per access (0..15).
REQ-005 The block SHALL have parameter CNT_BITS, default 16, the width of the statistics counters.
REQ-006 The block SHALL have port PCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port PRESETn, input, 1, reset, asynchronous, active-low.
REQ-008 The block SHALL have port PADDR, input, ADDR_BITS, the word address.
REQ-009 The block SHALL have ports PSEL, PENABLE and PWRITE, input, 1 each, standard APB3 control.
REQ-010 The block SHALL have port PWDATA, input, DATA_BITS, the write data.
REQ-011 The block SHALL have port PRDATA, output, DATA_BITS, the read data.
REQ-012 The block SHALL have ports PREADY and PSLVERR, output, 1 each, transfer complete and transfer error.
REQ-013 The block SHALL have ports write_count, read_count and err_count, output, CNT_BITS each, completed writes, completed reads and PSLVERR responses.
REQ-014 The block SHALL have port proto_err, output, 1, a sticky protocol-violation flag.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP and ACCESS.
REQ-016 In IDLE or ACCESS-complete, PSEL=1 with PENABLE=0 SHALL go to SETUP and latch PADDR, PWRITE and PWDATA, and load the wait counter with WAIT_STATES.
REQ-017 SETUP SHALL always go to ACCESS on the next edge.
REQ-018 In ACCESS, PREADY SHALL equal (wait counter == 0); the counter SHALL decrement each ACCESS cycle while nonzero.
REQ-019 An access SHALL complete in the cycle PSEL=PENABLE=PREADY=1, which is cycle WAIT_STATES+1 after SETUP; latency with WAIT_STATES=0 SHALL be 2 cycles.
REQ-020 On write completion with latched address < MEM_DEPTH, the latched PWDATA SHALL be stored and write_count incremented.
REQ-021 On read completion with address < MEM_DEPTH, PRDATA SHALL present mem[address] in the completion cycle and read_count SHALL increment.
REQ-022 On completion with address >= MEM_DEPTH, PSLVERR SHALL be 1, memory SHALL be unchanged, PRDATA SHALL be 0 and err_count SHALL increment.
REQ-023 PRDATA SHALL be 0 and PSLVERR SHALL be 0 in every cycle except a completing read or an error completion respectively.
REQ-024 PREADY SHALL be 1 in IDLE and SETUP, per APB3 convention.
REQ-025 Back-to-back: a new SETUP in the cycle after completion SHALL be accepted with no idle cycle.
REQ-026 Protocol violations SHALL set proto_err until reset: PENABLE=1 in the cycle after SETUP is missing; PSEL or PENABLE dropping in ACCESS before completion; PADDR, PWRITE or PWDATA differing from the latched values during ACCESS; PENABLE=1 with PSEL=1 in IDLE.
REQ-027 A violating transfer SHALL be aborted: FSM to IDLE, no memory write, no counter change.
REQ-028 Counters SHALL saturate at all-ones, not wrap.
REQ-029 Memory reads and writes SHALL be to the same address in the same cycle and never occur simultaneously, because only one transfer is in flight.

Reset
REQ-030 PRESETn low SHALL asynchronously force: FSM IDLE, wait counter 0, PREADY 1, PSLVERR 0, PRDATA 0, all counters 0, proto_err 0.
REQ-031 Memory contents SHALL NOT be reset and SHALL be undefined until written.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer without a memory write.

Structure
REQ-033 The FSM state encodings and the WAIT_STATES limit constant SHALL live in a shared include package, apb_tester_defs.
REQ-034 Storage SHALL be a sub-module apb_tester_ram: single-port, MEM_DEPTH x DATA_BITS, synchronous write, asynchronous read.

Verification
REQ-035 The bench SHALL cover: WAIT_STATES=0, write 0xA5 to addr 3, then read addr 3 -> PRDATA=0xA5 in the completion cycle; write_count=1, read_count=1.
REQ-036 The bench SHALL cover: WAIT_STATES=3, a single read -> PREADY low exactly 3 ACCESS cycles; completion 4 cycles after SETUP.
REQ-037 The bench SHALL cover: MEM_DEPTH=12, write to addr 13 -> PSLVERR=1 at completion, err_count=1, a later read of every addr 0..11 is unchanged.
REQ-038 The bench SHALL cover: PADDR changed from 2 to 5 during a waited ACCESS -> proto_err=1, write_count unchanged, no write to addr 2 or 5.
REQ-039 The bench SHALL cover: CNT_BITS=2 with 5 writes -> write_count=3; PRESETn pulse mid-ACCESS -> counters 0, PREADY 1, memory unchanged.
